// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA stream receiver: recovers pixel coordinates and strobes,
// measures line/frame timing, checks geometry and reports lock.
module vga_capture #(
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int SYNC_ACT_LOW = 1,
   parameter int LOCK_FRAMES  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        blank_n,
   input  logic [7:0]  vga_r,
   input  logic [7:0]  vga_g,
   input  logic [7:0]  vga_b,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [23:0] pix_data,
   output logic        line_done,
   output logic        frame_done,
   output logic [11:0] h_total,
   output logic [10:0] v_total,
   output logic [15:0] frame_cnt,
   output logic        locked,
   output logic        err
);

   localparam logic [9:0]  LP_HACT   = 10'(H_ACTIVE);
   localparam logic [11:0] LP_HACT12 = 12'(H_ACTIVE);
   localparam logic [9:0]  LP_VACT   = 10'(V_ACTIVE);
   localparam logic [7:0]  LP_LOCK   = 8'(LOCK_FRAMES);

   typedef enum logic {ST_SEEK, ST_CAPTURE} state_t;

   state_t      r_state;
   logic        r_hs_a, r_hs_p, r_vs_a, r_vs_p, r_blank;
   logic [23:0] r_rgb;
   logic [11:0] r_hclk;
   logic [10:0] r_vline;
   logic [9:0]  r_x, r_y;
   logic [11:0] r_lcnt;
   logic        r_frame_bad;
   logic [7:0]  r_good;

   logic        w_hs_in, w_vs_in;
   logic        w_hs_edge, w_vs_edge, w_cap;
   logic        w_pix_ok, w_over_y;
   logic [11:0] w_lcnt_nx;
   logic        w_line_had, w_line_bad;
   logic [9:0]  w_y_inc, w_y_nx;
   logic        w_fbad;
   logic [10:0] w_vline_nx;
   logic [7:0]  w_good_inc;

   // Sync inputs are normalised so that 1 always means "asserted"
   assign w_hs_in    = (SYNC_ACT_LOW != 0) ? ~hsync : hsync;
   assign w_vs_in    = (SYNC_ACT_LOW != 0) ? ~vsync : vsync;
   assign w_hs_edge  = r_hs_a & ~r_hs_p;
   assign w_vs_edge  = r_vs_a & ~r_vs_p;
   assign w_cap      = (r_state == ST_CAPTURE);

   assign w_pix_ok   = w_cap & r_blank & (r_x < LP_HACT) & (r_y < LP_VACT);
   assign w_over_y   = w_cap & r_blank & (r_y >= LP_VACT);

   assign w_lcnt_nx  = (r_blank && r_lcnt != 12'hfff) ? r_lcnt + 12'd1 : r_lcnt;
   assign w_line_had = (w_lcnt_nx != 12'd0);
   assign w_line_bad = w_line_had & (w_lcnt_nx != LP_HACT12);

   // Line end is folded in before the frame check so a coincident hsync edge counts
   assign w_y_inc    = (r_y == 10'h3ff) ? r_y : r_y + 10'd1;
   assign w_y_nx     = (w_hs_edge && w_line_had) ? w_y_inc : r_y;
   assign w_fbad     = r_frame_bad | w_over_y | (w_hs_edge & w_line_bad) | (w_y_nx != LP_VACT);

   assign w_vline_nx = (w_hs_edge && r_vline != 11'h7ff) ? r_vline + 11'd1 : r_vline;
   assign w_good_inc = (r_good == 8'hff) ? r_good : r_good + 8'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_SEEK;
         r_hs_a      <= 1'b0;
         r_hs_p      <= 1'b0;
         r_vs_a      <= 1'b0;
         r_vs_p      <= 1'b0;
         r_blank     <= 1'b0;
         r_rgb       <= '0;
         r_hclk      <= '0;
         r_vline     <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_lcnt      <= '0;
         r_frame_bad <= 1'b0;
         r_good      <= '0;
         pix_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         pix_data    <= '0;
         line_done   <= 1'b0;
         frame_done  <= 1'b0;
         h_total     <= '0;
         v_total     <= '0;
         frame_cnt   <= '0;
         locked      <= 1'b0;
         err         <= 1'b0;
      end else begin
         r_hs_a  <= w_hs_in;
         r_hs_p  <= r_hs_a;
         r_vs_a  <= w_vs_in;
         r_vs_p  <= r_vs_a;
         r_blank <= blank_n;
         r_rgb   <= {vga_r, vga_g, vga_b};

         // Timing measurement runs in every state
         if (w_hs_edge) begin
            h_total <= r_hclk;
            r_hclk  <= 12'd1;
         end else if (r_hclk != 12'hfff) begin
            r_hclk  <= r_hclk + 12'd1;
         end
         if (w_vs_edge) begin
            v_total <= w_vline_nx;
            r_vline <= '0;
         end else begin
            r_vline <= w_vline_nx;
         end

         pix_valid  <= w_pix_ok;
         line_done  <= 1'b0;
         frame_done <= 1'b0;
         if (w_pix_ok) begin
            pix_x    <= r_x;
            pix_y    <= r_y;
            pix_data <= r_rgb;
         end

         case (r_state)
            ST_SEEK: begin
               if (w_vs_edge) begin
                  r_state     <= ST_CAPTURE;
                  r_x         <= '0;
                  r_y         <= '0;
                  r_lcnt      <= '0;
                  r_frame_bad <= 1'b0;
               end
            end
            ST_CAPTURE: begin
               r_lcnt <= w_lcnt_nx;
               if (w_pix_ok) r_x <= r_x + 10'd1;
               if (w_over_y) r_frame_bad <= 1'b1;
               if (w_hs_edge) begin
                  r_lcnt <= '0;
                  if (w_line_had) begin
                     line_done <= 1'b1;
                     r_x       <= '0;
                     r_y       <= w_y_nx;
                     if (w_line_bad) r_frame_bad <= 1'b1;
                  end
               end
               if (w_vs_edge) begin
                  frame_done  <= 1'b1;
                  frame_cnt   <= frame_cnt + 16'd1;
                  r_x         <= '0;
                  r_y         <= '0;
                  r_lcnt      <= '0;
                  r_frame_bad <= 1'b0;
                  if (w_fbad) begin
                     err    <= 1'b1;
                     locked <= 1'b0;
                     r_good <= '0;
                  end else begin
                     r_good <= w_good_inc;
                     if (w_good_inc >= LP_LOCK) locked <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_SEEK;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - directed bench for vga_capture on a scaled 16x6 raster
// (24 clocks per line, 9 lines per frame, hsync at h=18..21, vsync on line 7).
module tb_vga_capture;

   logic        clk = 1'b0;
   logic        reset, hsync, vsync, blank_n;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        pix_valid, line_done, frame_done, locked, err;
   logic [9:0]  pix_x, pix_y;
   logic [23:0] pix_data;
   logic [11:0] h_total;
   logic [10:0] v_total;
   logic [15:0] frame_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int mon_x = 0, mon_y = 0, pv_cnt = 0, ld_cnt = 0, fd_cnt = 0, both_cnt = 0;
   int lat_drive = 0, lat_seen = 0, lat_x = -1, lat_y = -1, first_y = -1;
   logic [23:0] lat_d = '0;
   bit const_mode = 0, lat_arm = 0, lat_wait = 0, first_arm = 0;

   vga_capture #(.H_ACTIVE(16), .V_ACTIVE(6), .SYNC_ACT_LOW(1), .LOCK_FRAMES(2)) dut (
      .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
      .line_done(line_done), .frame_done(frame_done), .h_total(h_total),
      .v_total(v_total), .frame_cnt(frame_cnt), .locked(locked), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard on the falling edge: coordinates and data follow what was driven
   always @(negedge clk) begin
      if (pix_valid === 1'b1) begin
         check("pix_x", 32'(pix_x), mon_x);
         check("pix_y", 32'(pix_y), mon_y);
         check("pix_data", 32'(pix_data),
               const_mode ? 32'h00ff00ff : 32'({8'(mon_y), 8'(mon_x), 8'h5a}));
         if (lat_wait) begin
            lat_seen = cyc; lat_x = 32'(pix_x); lat_y = 32'(pix_y); lat_d = pix_data;
            lat_wait = 0;
         end
         if (first_arm) begin
            first_y = 32'(pix_y);
            first_arm = 0;
         end
         mon_x++;
         pv_cnt++;
      end
      if (line_done === 1'b1) begin
         check("line_pixels", mon_x, 16);
         mon_x = 0;
         mon_y++;
         ld_cnt++;
      end
      if (frame_done === 1'b1) begin
         if (line_done === 1'b1) both_cnt++;
         mon_y = 0;
         fd_cnt++;
      end
   end

   task automatic tick(input bit hs_a, input bit vs_a, input bit bl, input logic [23:0] rgb,
                       input bit rst);
      hsync   = ~hs_a;
      vsync   = ~vs_a;
      blank_n = bl;
      {vga_r, vga_g, vga_b} = rgb;
      reset   = rst;
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      pv_cnt = 0; ld_cnt = 0; fd_cnt = 0; both_cnt = 0;
   endtask

   // vs_mode: 0 none, 1 asserted whole line, 2 asserted from the hsync edge onward
   task automatic send_line(input int ln, input int npix, input int vs_mode, input int rst_at);
      for (int h = 0; h < 24; h++) begin
         bit bl, hs, vs, rst;
         logic [23:0] rgb;
         bl  = (h < npix);
         hs  = (h >= 18) && (h < 22);
         vs  = (vs_mode == 1) || ((vs_mode == 2) && (h >= 18));
         rst = (h == rst_at);
         rgb = !bl ? 24'h0 : (const_mode ? 24'hff00ff : {8'(ln), 8'(h), 8'h5a});
         if (bl && lat_arm) begin
            lat_drive = cyc; lat_arm = 0; lat_wait = 1;
         end
         tick(hs, vs, bl, rgb, rst);
         if (rst) begin
            check("rst_pix_valid", 32'(pix_valid), 0);
            check("rst_pix_x", 32'(pix_x), 0);
            check("rst_pix_data", 32'(pix_data), 0);
            check("rst_h_total", 32'(h_total), 0);
            check("rst_v_total", 32'(v_total), 0);
            check("rst_frame_cnt", 32'(frame_cnt), 0);
            check("rst_err", 32'(err), 0);
            check("rst_locked", 32'(locked), 0);
            mon_x = 0; mon_y = 0;
            clr();
         end
      end
   endtask

   // kind 0: vsync on line 7; kind 1: vsync edge coincides with line 5's hsync edge
   task automatic send_frame(input int n_act, input int long_line, input int kind,
                             input int rst_line);
      for (int ln = 0; ln < 9; ln++) begin
         int npix, vsm;
         npix = (ln < n_act) ? ((ln == long_line) ? 17 : 16) : 0;
         if (kind == 0) vsm = (ln == 7) ? 1 : 0;
         else           vsm = (ln == 5) ? 2 : ((ln == 6) ? 1 : 0);
         send_line(ln, npix, vsm, (ln == rst_line) ? 10 : -1);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: run did not complete");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 3; i++) tick(0, 0, 0, 24'h0, 1);
      check("reset_pix_valid", 32'(pix_valid), 0);
      check("reset_frame_cnt", 32'(frame_cnt), 0);
      check("reset_locked", 32'(locked), 0);
      check("reset_err", 32'(err), 0);
      check("reset_h_total", 32'(h_total), 0);

      // A: seek frame, no capture until its vsync
      clr(); send_frame(6, -1, 0, -1);
      check("A_pixels", pv_cnt, 0);
      check("A_frame_done", fd_cnt, 0);
      check("A_h_total", 32'(h_total), 24);

      // B: constant colour, latency of the very first pixel
      const_mode = 1; lat_arm = 1;
      clr(); send_frame(6, -1, 0, -1);
      const_mode = 0;
      check("lat_clocks", lat_seen - lat_drive, 2);
      check("lat_x", lat_x, 0);
      check("lat_y", lat_y, 0);
      check("lat_data", 32'(lat_d), 32'h00ff00ff);
      check("B_pixels", pv_cnt, 96);
      check("B_lines", ld_cnt, 6);
      check("B_frame_done", fd_cnt, 1);
      check("B_frame_cnt", 32'(frame_cnt), 1);
      check("B_v_total", 32'(v_total), 9);
      check("B_h_total", 32'(h_total), 24);
      check("B_locked", 32'(locked), 0);

      // C: second good frame -> lock
      clr(); send_frame(6, -1, 0, -1);
      check("C_locked", 32'(locked), 1);
      check("C_err", 32'(err), 0);
      check("C_frame_cnt", 32'(frame_cnt), 2);

      // D: line 2 carries 17 pixels
      clr(); send_frame(6, 2, 0, -1);
      check("D_pixels", pv_cnt, 96);
      check("D_err", 32'(err), 1);
      check("D_locked", 32'(locked), 0);
      check("D_frame_cnt", 32'(frame_cnt), 3);

      clr(); send_frame(6, -1, 0, -1);
      check("E_locked", 32'(locked), 0);
      clr(); send_frame(6, -1, 0, -1);
      check("F_locked", 32'(locked), 1);
      check("F_err", 32'(err), 1);

      // G: only 5 active lines
      clr(); send_frame(5, -1, 0, -1);
      check("G_frame_done", fd_cnt, 1);
      check("G_lines", ld_cnt, 5);
      check("G_err", 32'(err), 1);
      check("G_locked", 32'(locked), 0);
      check("G_frame_cnt", 32'(frame_cnt), 6);

      // H: one-clock reset mid line 1; nothing captured until the next vsync
      clr(); send_frame(6, -1, 0, 1);
      check("H_pixels", pv_cnt, 0);
      check("H_frame_done", fd_cnt, 0);
      check("H_frame_cnt", 32'(frame_cnt), 0);

      first_arm = 1;
      clr(); send_frame(6, -1, 0, -1);
      check("I_first_y", first_y, 0);
      check("I_pixels", pv_cnt, 96);
      check("I_frame_cnt", 32'(frame_cnt), 1);
      check("I_err", 32'(err), 0);

      // J: hsync and vsync leading edges together
      clr(); send_frame(6, -1, 1, -1);
      check("J_both_same_cycle", both_cnt, 1);
      check("J_frame_done", fd_cnt, 1);
      check("J_lines", ld_cnt, 6);
      check("J_locked", 32'(locked), 1);
      check("J_frame_cnt", 32'(frame_cnt), 2);

      first_y = -1; first_arm = 1;
      clr(); send_frame(6, -1, 0, -1);
      check("K_first_y", first_y, 0);
      check("K_pixels", pv_cnt, 96);
      check("K_err", 32'(err), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart of vga_ctrl, used in the emulator harness and in loopback tests.
- Samples the VGA pixel-clock-domain signals (HSYNC, VSYNC, BLANK_N, RGB) and recovers pixel coordinates and a pixel write strobe for a framebuffer or checker.
- Measures line and frame timing, flags geometry errors, and reports lock once the stream is stable.

Parameters:
- H_ACTIVE, 640, expected visible pixels per line
- V_ACTIVE, 480, expected visible lines per frame
- SYNC_ACT_LOW, 1, 1 = hsync/vsync asserted when low (vga_ctrl convention); 0 = asserted when high
- LOCK_FRAMES, 2, consecutive error-free frames required to assert locked

Ports:
- clk  in  1  pixel clock; same clock as VGA_CLK
- reset  in  1  synchronous, active-high reset
- hsync  in  1  VGA horizontal sync
- vsync  in  1  VGA vertical sync
- blank_n  in  1  1 = active video pixel
- vga_r / vga_g / vga_b  in  8 each  pixel colour
- pix_valid  out  1  one-cycle strobe per captured active pixel
- pix_x  out  10  column of the current pixel, 0..H_ACTIVE-1
- pix_y  out  10  row of the current pixel, 0..V_ACTIVE-1
- pix_data  out  24  {r,g,b} of the current pixel
- line_done  out  1  pulse at hsync leading edge ending a line that had ≥1 active pixel
- frame_done  out  1  pulse at vsync leading edge while in CAPTURE
- h_total  out  12  clocks between the last two hsync leading edges, saturating at 4095
- v_total  out  11  hsync leading edges between the last two vsync leading edges, saturating at 2047
- frame_cnt  out  16  completed frames, wraps at 65535 -> 0
- locked  out  1  stream geometry stable
- err  out  1  sticky: geometry error seen since reset

Behaviour:
- Reset (synchronous): all outputs 0; state SEEK; all counters and input registers cleared. Reset mid-frame discards the partial frame; capture restarts at the next vsync leading edge.
- Input stage: all inputs registered once. Sync polarity is normalised internally (hs_a, vs_a = asserted).
- Leading edge: registered asserted value is 1 and the previous sample was 0.
- Latency: exactly 2 clk from an input sample to the corresponding pix_valid, pix_x, pix_y and pix_data.
- State SEEK: pix_valid, line_done and frame_done held at 0. Timing measurement still runs. A vsync leading edge moves to CAPTURE with x=0, y=0.
- State CAPTURE:
  - Active pixel (blank_n=1): pix_valid=1 with current x, y and data, then x+1.
  - If x is already H_ACTIVE, the pixel is dropped (pix_valid=0) and the line is marked bad.
  - Pixels with y ≥ V_ACTIVE are dropped and the frame is marked bad.
- hsync leading edge:
  - h_total <= clk count since the previous hsync edge; the clk counter restarts at 1.
  - If the line had ≥1 active pixel: line_done pulse; a line is bad when its pixel count ≠ H_ACTIVE; y+1 (saturating at 1023); x <= 0.
- vsync leading edge:
  - v_total <= line count; frame_done pulse; frame_cnt+1.
  - Frame bad if active lines ≠ V_ACTIVE or any bad line occurred.
  - Then y <= 0, x <= 0.
  - The first vsync edge after SEEK does not pulse frame_done or check geometry.
- Simultaneous hsync and vsync leading edges: the line end is processed first (line_done and line check), then the frame end, in the same cycle. y ends at 0.
- Lock:
  - A good frame increments the good-frame counter.
  - At LOCK_FRAMES good frames, locked=1.
  - Any bad frame sets err=1, clears locked and the counter, and stays in CAPTURE.
- Counters never wrap silently except frame_cnt.

Test Plan:
- vga_ctrl-style 640x480 stream (800x525, hsync 96 low, vsync 2 lines low) -> after 1st vsync: h_total=800, v_total=525 at 2nd vsync; 640 pix_valid per line; x 0..639; y 0..479; locked=1 after the 3rd vsync edge; err=0.
- Constant 24'hff00ff, checking pix_data, latency and coordinates -> first pix_valid exactly 2 clk after the first blank_n=1 sample, with pix_x=0, pix_y=0, pix_data=24'hff00ff.
- One line with 641 active pixels -> the 641st pixel is not strobed; err=1 at the next vsync edge; locked falls to 0; it relocks after 2 clean frames while err stays 1.
- Frame with 479 active lines -> frame_done pulses; err=1; locked=0; frame_cnt still increments.
- Reset asserted for 1 clk mid-line, at x=300 -> all outputs 0 the next cycle; no pix_valid until the next vsync leading edge; the next frame starts at x=0, y=0.
- hsync and vsync leading edges in the same cycle -> line_done and frame_done both pulse in the same cycle; the next active pixel reports pix_y=0.
